// File: rtl/nn_layer_sequencer.sv
// Control FSM for the shared MAC datapath: two fully-connected layers, one neuron
// at a time, then argmax of the output scores onto digit_out/valid_out.
module nn_layer_sequencer #(
  parameter int N0      = 784,
  parameter int H1      = 32,
  parameter int OUT     = 10,
  parameter int MAC_LAT = 2,
  parameter int AW      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic signed [31:0] acc_in,
  output logic              busy,
  output logic              layer_sel,
  output logic [9:0]        in_addr,
  output logic [AW-1:0]     w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [3:0]        digit_out,
  output logic              valid_out
);

  localparam logic [9:0] L0_I_LAST = 10'(N0 - 1);
  localparam logic [9:0] L1_I_LAST = 10'(H1 - 1);
  localparam logic [4:0] L0_N_LAST = 5'(H1 - 1);
  localparam logic [4:0] L1_N_LAST = 5'(OUT - 1);
  localparam int         DW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] D_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_MAC, S_DRAIN, S_WRITE} state_t;

  state_t             r_state;
  logic               r_busy, r_layer_sel, r_mac_clr, r_mac_en, r_wr_en, r_valid;
  logic [9:0]         r_in_addr, r_i;
  logic [AW-1:0]      r_w_addr, r_wptr;
  logic [4:0]         r_wr_addr, r_n;
  logic [3:0]         r_digit, r_idx;
  logic [DW-1:0]      r_drain;
  logic signed [31:0] r_best;

  logic       w_better;
  logic [9:0] w_i_last;
  logic [4:0] w_n_last;

  assign w_better = (r_n == 5'd0) || (acc_in > r_best);
  assign w_i_last = r_layer_sel ? L1_I_LAST : L0_I_LAST;
  assign w_n_last = r_layer_sel ? L1_N_LAST : L0_N_LAST;

  // Weights of both layers are stored back to back, so one running pointer
  // walks the whole ROM in order across all neurons.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_layer_sel <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_valid     <= 1'b0;
      r_in_addr   <= '0;
      r_i         <= '0;
      r_w_addr    <= '0;
      r_wptr      <= '0;
      r_wr_addr   <= '0;
      r_n         <= '0;
      r_digit     <= '0;
      r_idx       <= '0;
      r_drain     <= '0;
      r_best      <= '0;
    end else if (abort && r_state != S_IDLE) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_layer_sel <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_mac_en    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_in_addr   <= '0;
      r_w_addr    <= '0;
      r_wr_addr   <= '0;
    end else begin
      r_mac_clr <= 1'b0;
      r_mac_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_in_addr <= '0;
      r_w_addr  <= '0;
      r_wr_addr <= '0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state     <= S_CLR;
            r_busy      <= 1'b1;
            r_layer_sel <= 1'b0;
            r_n         <= '0;
            r_wptr      <= '0;
            r_valid     <= 1'b0;
            r_mac_clr   <= 1'b1;
          end
        end
        S_CLR: begin
          r_i       <= '0;
          r_state   <= S_MAC;
          r_mac_en  <= 1'b1;
          r_in_addr <= '0;
          r_w_addr  <= r_wptr;
        end
        S_MAC: begin
          r_wptr <= r_wptr + AW'(1);
          if (r_i == w_i_last) begin
            if (MAC_LAT == 0) begin
              r_state   <= S_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_n;
            end else begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end else begin
            r_i       <= r_i + 10'd1;
            r_mac_en  <= 1'b1;
            r_in_addr <= r_i + 10'd1;
            r_w_addr  <= r_wptr + AW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain == D_LAST) begin
            r_state   <= S_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_n;
          end else begin
            r_drain <= r_drain + DW'(1);
          end
        end
        S_WRITE: begin
          if (r_layer_sel && w_better) begin
            r_best <= acc_in;
            r_idx  <= r_n[3:0];
          end
          if (r_n != w_n_last) begin
            r_n       <= r_n + 5'd1;
            r_state   <= S_CLR;
            r_mac_clr <= 1'b1;
          end else if (!r_layer_sel) begin
            r_layer_sel <= 1'b1;
            r_n         <= '0;
            r_state     <= S_CLR;
            r_mac_clr   <= 1'b1;
          end else begin
            // Last output neuron: fold its own score into the final decision.
            r_digit     <= w_better ? r_n[3:0] : r_idx;
            r_valid     <= 1'b1;
            r_busy      <= 1'b0;
            r_layer_sel <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign layer_sel = r_layer_sel;
  assign in_addr   = r_in_addr;
  assign w_addr    = r_w_addr;
  assign mac_clr   = r_mac_clr;
  assign mac_en    = r_mac_en;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign digit_out = r_digit;
  assign valid_out = r_valid;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench: two sequencer instances (default and small configuration),
// stimulus pushes expected results, per-instance monitors pop on valid_out rise.
module tb_nn_layer_sequencer;

  typedef struct {
    int     digit;
    longint t0;
    int     lat;
    int     nneu;
    int     nmac;
  } exp_t;

  localparam int P_N0  [2] = '{784, 4};
  localparam int P_H1  [2] = '{32, 2};
  localparam int P_OUT [2] = '{10, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_s   [2];
  logic               start_s   [2];
  logic               abort_s   [2];
  logic signed [31:0] acc_s     [2];
  logic               busy_s    [2];
  logic               layer_sel_s [2];
  logic [9:0]         in_addr_s [2];
  logic [14:0]        w_addr_s  [2];
  logic               mac_clr_s [2];
  logic               mac_en_s  [2];
  logic               wr_en_s   [2];
  logic [4:0]         wr_addr_s [2];
  logic [3:0]         digit_s   [2];
  logic               valid_s   [2];

  logic signed [31:0] scores [2][32];
  exp_t sb_q [2][$];
  int total = 0;
  int bad = 0;

  nn_layer_sequencer #(.N0(784), .H1(32), .OUT(10), .MAC_LAT(2), .AW(15)) u_dut_big (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .abort(abort_s[0]),
    .acc_in(acc_s[0]), .busy(busy_s[0]), .layer_sel(layer_sel_s[0]),
    .in_addr(in_addr_s[0]), .w_addr(w_addr_s[0]), .mac_clr(mac_clr_s[0]),
    .mac_en(mac_en_s[0]), .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]),
    .digit_out(digit_s[0]), .valid_out(valid_s[0])
  );

  nn_layer_sequencer #(.N0(4), .H1(2), .OUT(3), .MAC_LAT(0), .AW(15)) u_dut_small (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .abort(abort_s[1]),
    .acc_in(acc_s[1]), .busy(busy_s[1]), .layer_sel(layer_sel_s[1]),
    .in_addr(in_addr_s[1]), .w_addr(w_addr_s[1]), .mac_clr(mac_clr_s[1]),
    .mac_en(mac_en_s[1]), .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]),
    .digit_out(digit_s[1]), .valid_out(valid_s[1])
  );

  task automatic chk(input string nm, input int d, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s[dut%0d]: actual=%0d required=%0d", nm, d, act, req);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    // Datapath stand-in: layer-2 scores come from the table, layer 1 is irrelevant.
    assign acc_s[gi] = layer_sel_s[gi] ? scores[gi][wr_addr_s[gi]] : 32'sd1000;

    int k = 0, j = 0, n_clr = 0, n_mac = 0, n_wr = 0, n_busy = 0, aerr = 0;
    logic pb = 1'b0, pv = 1'b0;

    always @(negedge clk) begin : mon
      exp_t e;
      int lay1, nn, ew;
      if (busy_s[gi] && !pb) begin
        k = -1; j = 0; n_clr = 0; n_mac = 0; n_wr = 0; n_busy = 0; aerr = 0;
      end
      if (busy_s[gi]) n_busy++;
      if (mac_clr_s[gi]) begin k++; j = 0; n_clr++; end
      if (wr_en_s[gi]) n_wr++;
      if (mac_en_s[gi]) begin
        lay1 = (k >= P_H1[gi]) ? 1 : 0;
        nn   = lay1 ? k - P_H1[gi] : k;
        ew   = lay1 ? P_H1[gi] * P_N0[gi] + nn * P_H1[gi] + j : nn * P_N0[gi] + j;
        if (int'(w_addr_s[gi]) != ew || int'(in_addr_s[gi]) != j || int'(layer_sel_s[gi]) != lay1)
          aerr++;
        if (k == 1 && j == 0) begin
          chk("l0_n1_first_w_addr", gi, w_addr_s[gi], P_N0[gi]);
          chk("l0_n1_first_in_addr", gi, in_addr_s[gi], 0);
        end
        if (k == P_H1[gi] && j == 0) begin
          chk("l1_n0_first_w_addr", gi, w_addr_s[gi], P_H1[gi] * P_N0[gi]);
          chk("l1_n0_layer_sel", gi, layer_sel_s[gi], 1);
        end
        if (k == P_H1[gi] + P_OUT[gi] - 1 && j == P_H1[gi] - 1) begin
          chk("l1_last_w_addr", gi, w_addr_s[gi], P_H1[gi] * P_N0[gi] + P_OUT[gi] * P_H1[gi] - 1);
          chk("l1_last_in_addr", gi, in_addr_s[gi], P_H1[gi] - 1);
        end
        j++;
        n_mac++;
      end
      if (valid_s[gi] && !pv) begin
        if (sb_q[gi].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid[dut%0d]: actual=1 required=0", gi);
        end else begin
          e = sb_q[gi].pop_front();
          chk("digit", gi, digit_s[gi], e.digit);
          chk("latency", gi, ($time - 5 - e.t0) / 10, e.lat);
          chk("busy_at_valid", gi, busy_s[gi], 0);
          chk("busy_cycles", gi, n_busy, e.lat);
          chk("wr_pulses", gi, n_wr, e.nneu);
          chk("clr_pulses", gi, n_clr, e.nneu);
          chk("mac_cycles", gi, n_mac, e.nmac);
          chk("addr_trace_errors", gi, aerr, 0);
          $display("result dut%0d: digit=%0d expected=%0d", gi, digit_s[gi], e.digit);
        end
      end
      pb = busy_s[gi];
      pv = valid_s[gi];
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_start(input int d, input bit push, input int dig, input int lat,
                          input int nneu, input int nmac);
    exp_t e;
    start_s[d] = 1'b1;
    @(posedge clk);
    if (push) begin
      e.digit = dig; e.t0 = $time; e.lat = lat; e.nneu = nneu; e.nmac = nmac;
      sb_q[d].push_back(e);
    end
    @(negedge clk);
    start_s[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    for (int c = 0; c < 30000 && sb_q[d].size() != 0; c++) @(negedge clk);
    chk("done_in_time", d, sb_q[d].size(), 0);
    sb_q[d].delete();
  endtask

  task automatic chk_reset_outs(input int d, input string nm);
    chk({nm, "_ctrl"}, d, {busy_s[d], layer_sel_s[d], mac_clr_s[d], mac_en_s[d],
                           wr_en_s[d], valid_s[d]}, 0);
    chk({nm, "_addr"}, d, {in_addr_s[d], w_addr_s[d], wr_addr_s[d], digit_s[d]}, 0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1; start_s[d] = 1'b0; abort_s[d] = 1'b0;
      for (int n = 0; n < 32; n++) scores[d][n] = 32'sd0;
    end
    repeat (2) @(negedge clk);
    reset_s[0] = 1'b0; reset_s[1] = 1'b0;
    chk_reset_outs(0, "reset");
    chk_reset_outs(1, "reset");

    // Small configuration: two back-to-back runs with identical timing.
    scores[1][0] = 32'sd50; scores[1][1] = 32'sd1; scores[1][2] = 32'sd2;
    do_start(1, 1'b1, 0, 24, 5, 14);
    for (int c = 0; c < 100 && !valid_s[1]; c++) @(negedge clk);
    scores[1][0] = 32'sd1; scores[1][1] = 32'sd2; scores[1][2] = 32'sd30;
    do_start(1, 1'b1, 2, 24, 5, 14);
    wait_done(1);
    chk("prev_valid", 1, valid_s[1], 1);
    chk("prev_digit", 1, digit_s[1], 2);

    // Reset while in layer 2 wipes everything, including the held result.
    do_start(1, 1'b0, 0, 0, 0, 0);
    repeat (14) @(negedge clk);
    chk("in_layer2_before_reset", 1, {busy_s[1], layer_sel_s[1]}, 2'b11);
    reset_s[1] = 1'b1;
    @(negedge clk);
    reset_s[1] = 1'b0;
    chk_reset_outs(1, "mid_reset");

    // start together with abort in IDLE is ignored.
    start_s[1] = 1'b1; abort_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0; abort_s[1] = 1'b0;
    chk("start_abort_idle", 1, {busy_s[1], mac_clr_s[1]}, 0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle_later", 1, busy_s[1], 0);

    // Default configuration, basic argmax, with an ignored start at cycle 500.
    for (int n = 0; n < 32; n++) scores[0][n] = -32'sd100 + n;
    scores[0][7] = 32'sd500;
    do_start(0, 1'b1, 7, 25576, 42, 25408);
    repeat (499) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    wait_done(0);

    // Abort at cycle 1000.
    do_start(0, 1'b0, 0, 0, 0, 0);
    repeat (999) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    chk("abort_busy_valid", 0, {busy_s[0], valid_s[0]}, 0);
    chk("abort_strobes", 0, {mac_clr_s[0], mac_en_s[0], wr_en_s[0]}, 0);
    chk("abort_digit_kept", 0, digit_s[0], 7);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 0, {busy_s[0], valid_s[0]}, 0);

    // Tie at 300 between n=3 and n=8: lower index wins.
    for (int n = 0; n < 32; n++) scores[0][n] = -32'sd10 * n;
    scores[0][3] = 32'sd300; scores[0][8] = 32'sd300;
    do_start(0, 1'b1, 3, 25576, 42, 25408);
    wait_done(0);

    // All negative, maximum -40 at n=9.
    for (int n = 0; n < 32; n++) scores[0][n] = -32'sd1000 - n;
    scores[0][9] = -32'sd40;
    do_start(0, 1'b1, 9, 25576, 42, 25408);
    wait_done(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Control FSM that sequences the shared multiply-accumulate datapath of the MNIST network inside `top_nn`. It runs two fully-connected layers (input→hidden with ReLU, hidden→output), one neuron at a time, then runs argmax over the output scores. The result appears on the `digit_out`/`valid_out` pair that `top_nn` exports. The block issues all memory addresses and MAC strobes; the datapath (MAC, bias add, ReLU, buffers) lives outside.

## Interface
- `N0`, 784: layer-1 fan-in (pixel count)
- `H1`, 32: hidden neurons = layer-2 fan-in
- `OUT`, 10: output neurons (≤16)
- `MAC_LAT`, 2: cycles from last `mac_en` until `acc_in` is final (0 allowed)
- `AW`, 15: weight address width; must hold H1·N0 + OUT·H1

- `clk` in 1: clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin inference; sampled only in IDLE.
- `abort` in 1: synchronous cancel; return to IDLE.
- `acc_in` in 32 signed: biased accumulator from the datapath, valid in WRITE.
- `busy` out 1: high from the cycle after `start` is accepted until the return to IDLE.
- `layer_sel` out 1: 0 = layer 1 (read image buffer), 1 = layer 2 (read hidden buffer).
- `in_addr` out 10: activation read address.
- `w_addr` out AW: weight ROM address.
- `mac_clr` out 1: clear accumulator.
- `mac_en` out 1: accumulate the current product.
- `wr_en` out 1: neuron result strobe; layer 1 writes ReLU(acc_in) to the hidden buffer.
- `wr_addr` out 5: neuron index n; also the bias address.
- `digit_out` out 4: argmax index.
- `valid_out` out 1: result valid, level-held.

## Operation
- **States:** IDLE, CLR, MAC, DRAIN, WRITE.
- **IDLE**
  - `start`=1 and `abort`=0: go to CLR, layer=0, n=0, `valid_out`←0.
  - Otherwise stay.
- **CLR** (1 cycle)
  - `mac_clr`=1, i←0.
  - Next state MAC.
- **MAC** (N_in cycles; N_in = N0 for layer 0, H1 for layer 1)
  - `mac_en`=1, `in_addr`=i.
  - Layer 0: `w_addr` = n·N0 + i.
  - Layer 1: `w_addr` = H1·N0 + n·H1 + i.
  - i increments each cycle. After i = N_in−1, go to DRAIN, or to WRITE if MAC_LAT=0.
- **DRAIN** (MAC_LAT cycles): all strobes 0.
- **WRITE** (1 cycle)
  - `wr_en`=1, `wr_addr`=n.
  - Layer 1 argmax update:
    - If n=0, or `acc_in` > best (signed, strictly greater), then best←`acc_in`, idx←n.
    - Ties keep the lower index.
  - Next step:
    - If n < N_layer−1: n++, go to CLR.
    - Else if layer 0: layer←1, n←0, go to CLR.
    - Else: `digit_out`←idx, `valid_out`←1, go to IDLE.
- `valid_out` and `digit_out` hold until the next accepted `start`, which clears `valid_out`. `digit_out` keeps its old value.
- Strobes, `in_addr` and `w_addr` are registered outputs. They are 0 in any state where they are not defined above.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state: next cycle is IDLE, `busy`=0, all strobes 0, `valid_out` stays 0, `digit_out` unchanged.
- `abort` together with `start` in IDLE: the block stays in IDLE.

## Timing
- **Reset values:** state IDLE; `busy`, `mac_clr`, `mac_en`, `wr_en`, `layer_sel`, `valid_out` = 0; `in_addr`, `w_addr`, `wr_addr`, `digit_out` = 0; best/idx cleared.
- **Reset mid-inference:** same as the reset values, effective on the next cycle. Nothing is retained.
- **Per-neuron cycles:** N_in + MAC_LAT + 2.
- **Total latency:** `start` sampled at edge E0 → `valid_out` high after edge E0 + H1·(N0+MAC_LAT+2) + OUT·(H1+MAC_LAT+2).
  - Defaults: E0+25576.
- `busy` falls on the same edge that `valid_out` rises.
- A new `start` is accepted in the cycle immediately after `valid_out` rises.
- **Widths:** the `w_addr` maximum H1·N0+OUT·H1−1 = 25407 < 2^15. Counters never wrap.

## Test plan
- **Default parameters, basic argmax.** Reset 2 cycles, then `start` pulse. Model drives `acc_in` = −100+n in layer 1, except n=7 gets +500. → `digit_out`=7, `valid_out` at E0+25576, `busy` high throughout, exactly 32+10 `wr_en` pulses.
- **Tie-break and signed compare.**
  - Scores equal to 300 at n=3 and n=8, all others lower → 3.
  - All scores negative, −40 at n=9 as the maximum → 9.
- **Address trace.**
  - Layer 0, n=1, first MAC: `w_addr`=784, `in_addr`=0.
  - Layer 1, n=0, first MAC: `w_addr`=25088, `layer_sel`=1.
  - Layer 1, n=9, last MAC: `w_addr`=25407, `in_addr`=31.
  - `mac_clr` precedes every neuron's MAC burst.
- **Start and abort handling.**
  - `start` re-pulsed at cycle 500 → ignored.
  - `abort` at cycle 1000 → IDLE next cycle, `busy`=0, `valid_out` stays 0.
  - A following `start` runs a full inference.
  - `start`+`abort` in the same cycle in IDLE → stays IDLE.
- **Reset mid-operation.** Assert `reset` in layer 1 → all outputs at reset values next cycle. A previous `valid_out`=1, `digit_out`=5 is cleared to 0/0.
- **Small configuration.** N0=4, H1=2, OUT=3, MAC_LAT=0 → `valid_out` at E0+24, no DRAIN state visited, second back-to-back run gives identical timing.
